rec_play_ctrl: RTL and testbench

REC_PLAY_CTRL -- requirements
Module: rec_play_ctrl

---
 rtl/piano_pkg.sv | 20 ++
 rtl/rec_mem.sv | 22 ++
 rtl/rec_play_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rec_play_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared types and constants for the piano record/playback controller.
package piano_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_REC  = 2'd1,
    MODE_PLAY = 2'd2
  } mode_t;

  localparam logic [2:0] NOTE_NONE = 3'b111;
  localparam int ENTRY_W = 9;
  localparam int DUR_W   = 4;

  typedef struct packed {
    logic [2:0]       code;
    logic [1:0]       tone;
    logic [DUR_W-1:0] dur;
  } entry_t;

endpackage

// File: rtl/rec_mem.sv
// Single-port recording memory: synchronous write, registered read.
module rec_mem
  import piano_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback controller for the piano keyboard (run-length note memory).
// Define LOOP_PLAY_EN to make playback wrap to entry 0 until stop_btn.
module rec_play_ctrl
  import piano_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int DUR_MAX = 15
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic [2:0]               key_code,
  input  logic [1:0]               key_tone,
  input  logic                     step_tick,
  input  logic                     rec_btn,
  input  logic                     play_btn,
  input  logic                     stop_btn,
  output logic [2:0]               note_code,
  output logic [1:0]               note_tone,
  output logic [1:0]               mode,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [DUR_W-1:0] DUR_LIM  = DUR_W'(DUR_MAX);

  mode_t            state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             full_r, full_n;
  logic [AW-1:0]    wr_ptr, wr_ptr_n;
  logic [AW-1:0]    rd_ptr, rd_ptr_n;
  logic [2:0]       cur_code, cur_code_n;
  logic [1:0]       cur_tone, cur_tone_n;
  logic [DUR_W-1:0] cur_dur, cur_dur_n;
  logic [DUR_W-1:0] remain, remain_n, remain_eff;
  logic             load_pend, load_pend_n;
  logic [2:0]       live_code;
  logic [1:0]       live_tone;

  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [ENTRY_W-1:0] mem_wdata;
  logic [ENTRY_W-1:0] mem_rdata;
  entry_t             rd_entry;
  logic [CW-1:0]      cnt_m1;
  logic               same_note;
  logic               last_entry;

  assign rd_entry   = entry_t'(mem_rdata);
  assign cnt_m1     = cnt - CW'(1);
  assign last_entry = ({1'b0, rd_ptr} == cnt_m1);
  assign same_note  = ({key_code, key_tone} == {cur_code, cur_tone});
  // The read data lands one cycle after an entry is selected, so remain is
  // taken straight from the memory output on that cycle.
  assign remain_eff = load_pend ? rd_entry.dur : remain;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    full_n      = full_r;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    cur_code_n  = cur_code;
    cur_tone_n  = cur_tone;
    cur_dur_n   = cur_dur;
    remain_n    = remain_eff;
    load_pend_n = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = {cur_code, cur_tone, cur_dur};

    unique case (state)
      MODE_IDLE: begin
        if (stop_btn) begin
          state_n = MODE_IDLE;
        end else if (rec_btn) begin
          state_n   = MODE_REC;
          cnt_n     = '0;
          full_n    = 1'b0;
          wr_ptr_n  = '0;
          cur_dur_n = '0;
        end else if (play_btn && cnt != '0) begin
          state_n     = MODE_PLAY;
          rd_ptr_n    = '0;
          load_pend_n = 1'b1;
        end
      end

      MODE_REC: begin
        if (stop_btn) begin
          if (cur_dur != '0 && cnt != CNT_FULL) begin
            mem_we   = 1'b1;
            cnt_n    = cnt + CW'(1);
            wr_ptr_n = wr_ptr + AW'(1);
          end
          state_n = MODE_IDLE;
        end else if (step_tick) begin
          if (cur_dur == '0) begin
            cur_code_n = key_code;
            cur_tone_n = key_tone;
            cur_dur_n  = DUR_W'(1);
          end else if (same_note && cur_dur < DUR_LIM) begin
            cur_dur_n = cur_dur + DUR_W'(1);
          end else if (cnt == CNT_FULL) begin
            full_n  = 1'b1;
            state_n = MODE_IDLE;
          end else begin
            mem_we     = 1'b1;
            cnt_n      = cnt + CW'(1);
            wr_ptr_n   = wr_ptr + AW'(1);
            cur_code_n = key_code;
            cur_tone_n = key_tone;
            cur_dur_n  = DUR_W'(1);
          end
        end
      end

      MODE_PLAY: begin
        if (stop_btn) begin
          state_n = MODE_IDLE;
        end else if (step_tick) begin
          if (remain_eff <= DUR_W'(1)) begin
            if (last_entry) begin
`ifdef LOOP_PLAY_EN
              rd_ptr_n    = '0;
              load_pend_n = 1'b1;
`else
              state_n = MODE_IDLE;
`endif
            end else begin
              rd_ptr_n    = rd_ptr + AW'(1);
              load_pend_n = 1'b1;
            end
          end else begin
            remain_n = remain_eff - DUR_W'(1);
          end
        end
      end

      default: state_n = MODE_IDLE;
    endcase
  end

  // Reads follow the next pointer so the selected entry is on rdata right
  // after the tick that selects it, even with back-to-back ticks.
  assign mem_addr = mem_we ? wr_ptr : rd_ptr_n;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= MODE_IDLE;
      cnt       <= '0;
      full_r    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cur_code  <= NOTE_NONE;
      cur_tone  <= '0;
      cur_dur   <= '0;
      remain    <= '0;
      load_pend <= 1'b0;
      live_code <= NOTE_NONE;
      live_tone <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      full_r    <= full_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      cur_code  <= cur_code_n;
      cur_tone  <= cur_tone_n;
      cur_dur   <= cur_dur_n;
      remain    <= remain_n;
      load_pend <= load_pend_n;
      live_code <= key_code;
      live_tone <= key_tone;
    end
  end

  rec_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (sysclk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign note_code = (state == MODE_PLAY) ? rd_entry.code : live_code;
  assign note_tone = (state == MODE_PLAY) ? rd_entry.tone : live_tone;
  assign mode      = state;
  assign full      = full_r;
  assign count     = cnt;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Self-checking bench for rec_play_ctrl: queue-based model checked every cycle
// plus directed literal expectations. Honours LOOP_PLAY_EN like the design.
module tb_rec_play_ctrl;

  localparam int DEPTH   = 4;
  localparam int DUR_MAX = 15;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          sysclk = 1'b0;
  logic          rst;
  logic [2:0]    key_code;
  logic [1:0]    key_tone;
  logic          step_tick, rec_btn, play_btn, stop_btn;
  logic [2:0]    note_code;
  logic [1:0]    note_tone;
  logic [1:0]    mode;
  logic          full;
  logic [CW-1:0] count;

  always #5 sysclk = ~sysclk;

  rec_play_ctrl #(.DEPTH(DEPTH), .DUR_MAX(DUR_MAX)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .key_code  (key_code),
    .key_tone  (key_tone),
    .step_tick (step_tick),
    .rec_btn   (rec_btn),
    .play_btn  (play_btn),
    .stop_btn  (stop_btn),
    .note_code (note_code),
    .note_tone (note_tone),
    .mode      (mode),
    .full      (full),
    .count     (count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: recording is a queue of (code,tone,dur) runs; playback
  // walks the queue counting ticks elapsed inside the current run.
  int m_mode = 0;
  int m_full = 0;
  int live_c = 7, live_t = 0;
  int cur_c = 7, cur_t = 0, cur_d = 0;
  int idx = 0, elapsed = 0;
  int q_code[$], q_tone[$], q_dur[$];

  task automatic push_cur();
    q_code.push_back(cur_c);
    q_tone.push_back(cur_t);
    q_dur.push_back(cur_d);
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_full = 0; cur_d = 0; idx = 0; elapsed = 0;
      q_code.delete(); q_tone.delete(); q_dur.delete();
      live_c = 7; live_t = 0;
    end else begin
      case (m_mode)
        0: begin
          if (stop_btn) begin
          end else if (rec_btn) begin
            m_mode = 1; m_full = 0; cur_d = 0;
            q_code.delete(); q_tone.delete(); q_dur.delete();
          end else if (play_btn && q_code.size() > 0) begin
            m_mode = 2; idx = 0; elapsed = 0;
          end
        end
        1: begin
          if (stop_btn) begin
            if (cur_d > 0 && q_code.size() < DEPTH) push_cur();
            m_mode = 0;
          end else if (step_tick) begin
            if (cur_d == 0) begin
              cur_c = int'(key_code); cur_t = int'(key_tone); cur_d = 1;
            end else if (int'(key_code) == cur_c && int'(key_tone) == cur_t && cur_d < DUR_MAX) begin
              cur_d++;
            end else if (q_code.size() == DEPTH) begin
              m_full = 1; m_mode = 0;
            end else begin
              push_cur();
              cur_c = int'(key_code); cur_t = int'(key_tone); cur_d = 1;
            end
          end
        end
        default: begin
          if (stop_btn) begin
            m_mode = 0;
          end else if (step_tick) begin
            elapsed++;
            if (elapsed >= q_dur[idx]) begin
              elapsed = 0;
              if (idx == q_code.size() - 1) begin
`ifdef LOOP_PLAY_EN
                idx = 0;
`else
                m_mode = 0;
`endif
              end else begin
                idx++;
              end
            end
          end
        end
      endcase
      live_c = int'(key_code);
      live_t = int'(key_tone);
    end
  endtask

  always @(posedge sysclk) model_step();

  bit chk_en = 1'b0;
  always @(negedge sysclk) begin
    if (chk_en) begin
      check("cyc_note_code", int'(note_code), (m_mode == 2) ? q_code[idx] : live_c);
      check("cyc_note_tone", int'(note_tone), (m_mode == 2) ? q_tone[idx] : live_t);
      check("cyc_mode",      int'(mode),      m_mode);
      check("cyc_count",     int'(count),     q_code.size());
      check("cyc_full",      int'(full),      m_full);
    end
  end

  // Inputs are held across exactly one rising edge; returns on the next falling edge.
  task automatic cycle(input int c, input int t, input int tk, input int r, input int p, input int s);
    key_code  = 3'(c);
    key_tone  = 2'(t);
    step_tick = tk[0];
    rec_btn   = r[0];
    play_btn  = p[0];
    stop_btn  = s[0];
    @(negedge sysclk);
  endtask

  task automatic tk_gap(input int c, input int t);
    cycle(c, t, 1, 0, 0, 0);
    cycle(7, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int notes[6];
    int n;
    notes = '{0, 7, 1, 2, 3, 4};
    rst = 1'b1;
    key_code = 3'd3; key_tone = 2'd0;
    step_tick = 1'b0; rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
    @(negedge sysclk);
    chk_en = 1'b1;

    // Reset state and pass-through latency
    cycle(3, 0, 0, 0, 0, 0);
    check("rst_note", int'(note_code), 7);
    check("rst_mode", int'(mode), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0;
    cycle(3, 0, 0, 0, 0, 0);
    check("pass_note", int'(note_code), 3);

    // Record key 2 x3 ticks, key 5 x2 ticks
    cycle(3, 0, 0, 1, 0, 0);
    check("rec_enter", int'(mode), 1);
    repeat (3) tk_gap(2, 1);
    repeat (2) tk_gap(5, 2);
    cycle(0, 0, 0, 0, 0, 1);
    check("rec_count", int'(count), 2);
    check("rec_exit", int'(mode), 0);

    // Playback with gaps between ticks
    cycle(4, 0, 0, 0, 1, 0);
    check("play_mode", int'(mode), 2);
    check("play_e0_code", int'(note_code), 2);
    check("play_e0_tone", int'(note_tone), 1);
    for (int i = 1; i <= 5; i++) begin
      cycle(4, 0, 1, 0, 0, 0);
      if (i < 5) check("play_seq", int'(note_code), (i < 3) ? 2 : 5);
      cycle(4, 0, 0, 0, 0, 0);
    end
`ifdef LOOP_PLAY_EN
    check("loop_mode", int'(mode), 2);
    check("loop_e0", int'(note_code), 2);
`else
    check("end_mode", int'(mode), 0);
    check("end_pass", int'(note_code), 4);
`endif
    cycle(4, 0, 0, 0, 0, 1);

    // Back-to-back ticks, rec_btn ignored while playing
    cycle(1, 3, 0, 0, 1, 0);
    cycle(1, 3, 1, 0, 0, 0);
    cycle(1, 3, 1, 1, 0, 0);
    check("play_rec_ign", int'(mode), 2);
    repeat (5) cycle(1, 3, 1, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 1);

    // Stop mid-playback
    cycle(6, 0, 0, 0, 1, 0);
    cycle(6, 0, 1, 0, 0, 0);
    cycle(6, 1, 0, 0, 0, 1);
    check("stop_play_mode", int'(mode), 0);
    check("stop_play_note", int'(note_code), 6);

    // Long hold splits at DUR_MAX
    cycle(0, 0, 0, 1, 0, 0);
    repeat (20) cycle(6, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("hold_count", int'(count), 2);
    cycle(1, 0, 0, 0, 1, 0);
`ifdef LOOP_PLAY_EN
    repeat (25) cycle(1, 0, 1, 0, 0, 0);
    check("hold_loop_mode", int'(mode), 2);
    check("hold_loop_note", int'(note_code), 6);
    cycle(1, 0, 0, 0, 0, 1);
`else
    n = 0;
    while (mode == 2'd2 && n < 40) begin
      cycle(1, 0, 1, 0, 0, 0);
      n++;
    end
    check("hold_ticks", n, 20);
`endif

    // rec+play together -> REC; overflow on the fifth write
    cycle(0, 0, 0, 1, 1, 0);
    check("rec_prio", int'(mode), 1);
    for (int i = 0; i < 6; i++) tk_gap(notes[i], i % 4);
    check("ovf_full", int'(full), 1);
    check("ovf_count", int'(count), 4);
    check("ovf_mode", int'(mode), 0);
    cycle(5, 1, 0, 0, 1, 0);
    check("ovf_play_e0", int'(note_code), 0);
    cycle(5, 1, 1, 0, 0, 0);
    check("ovf_play_rest", int'(note_code), 7);
    repeat (4) cycle(5, 1, 1, 0, 0, 0);
    cycle(5, 1, 0, 0, 0, 1);

    // stop beats rec in IDLE; stop with tick in REC ignores the tick
    cycle(2, 0, 0, 1, 0, 1);
    check("stop_prio", int'(mode), 0);
    cycle(2, 0, 0, 1, 0, 0);
    check("rec_clr_full", int'(full), 0);
    tk_gap(1, 0);
    cycle(1, 0, 0, 0, 1, 0);
    check("rec_play_ign", int'(mode), 1);
    tk_gap(1, 0);
    cycle(3, 0, 1, 0, 0, 1);
    check("flush_count", int'(count), 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("flush_dur", int'(note_code), 1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Exactly full: final flush is dropped without setting full
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tk_gap(i, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("exact_count", int'(count), 4);
    check("exact_full", int'(full), 0);

    // Reset mid-REC and mid-PLAY
    cycle(0, 0, 0, 1, 0, 0);
    tk_gap(2, 0);
    rst = 1'b1;
    cycle(2, 0, 0, 0, 0, 0);
    check("rst_rec_mode", int'(mode), 0);
    rst = 1'b0;
    cycle(0, 0, 0, 1, 0, 0);
    tk_gap(2, 0);
    tk_gap(3, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    cycle(5, 2, 0, 0, 0, 0);
    check("rst_play_mode", int'(mode), 0);
    check("rst_play_count", int'(count), 0);
    check("rst_play_note", int'(note_code), 7);
    rst = 1'b0;
    cycle(5, 2, 0, 0, 1, 0);
    check("play_empty", int'(mode), 0);
    cycle(5, 2, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1);
  end

endmodule
